// File: rtl/ninjin_m_axi_memtest.sv
// AXI4 master memory tester: writes a pattern over a DDR region, reads it back, checks it.
module ninjin_m_axi_memtest #(
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    xrst,
    input  logic                    req,
    input  logic [1:0]              mode,
    input  logic                    abort_en,
    input  logic [CNT_WIDTH-1:0]    nburst,
    input  logic [ADDR_WIDTH-1:0]   base,
    input  logic [DATA_WIDTH-1:0]   seed,
    output logic                    busy,
    output logic                    ack,
    output logic [3:0]              err,
    output logic [CNT_WIDTH-1:0]    err_cnt,
    output logic [ADDR_WIDTH-1:0]   err_addr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast
);

    localparam int unsigned BYTES       = DATA_WIDTH / 8;
    localparam int unsigned SIZE        = $clog2(BYTES);
    localparam int unsigned BURST_BYTES = BURST_LEN * BYTES;
    localparam int unsigned GW          = CNT_WIDTH + 8;
    localparam int unsigned RW          = $clog2(DATA_WIDTH);
    localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WADDR, S_WDATA, S_WRESP, S_RADDR, S_RDATA, S_DONE
    } state_t;

    state_t                  state, state_d;
    logic                    req_q, start;
    logic [1:0]              mode_q, mode_d;
    logic                    abort_q, abort_d;
    logic [CNT_WIDTH-1:0]    nburst_q, nburst_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [DATA_WIDTH-1:0]   seed_q, seed_d;
    logic [7:0]              beat, beat_d;
    logic [CNT_WIDTH-1:0]    burst, burst_d;
    logic [GW-1:0]           g, g_d;
    logic [ADDR_WIDTH-1:0]   addr, addr_d;
    logic [3:0]              err_d;
    logic [CNT_WIDTH-1:0]    err_cnt_d;
    logic [ADDR_WIDTH-1:0]   err_addr_d;
    logic                    ack_d;
    logic [DATA_WIDTH-1:0]   exp_data;
    logic                    unused_resp;

    // Pattern value for global beat index gi
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] m,
                                                      input logic [DATA_WIDTH-1:0] s,
                                                      input logic [GW-1:0] gi);
        logic [DATA_WIDTH-1:0]   gx;
        logic [2*DATA_WIDTH-1:0] dbl;
        logic [RW-1:0]           r;
        gx  = DATA_WIDTH'(gi);
        r   = gi[RW-1:0];
        dbl = {s, s} << r;
        case (m)
            2'd0:    pattern = s + gx;
            2'd1:    pattern = ~(s + gx);
            2'd2:    pattern = dbl[2*DATA_WIDTH-1:DATA_WIDTH];
            default: pattern = s;
        endcase
    endfunction

    assign awlen   = LAST_BEAT;
    assign arlen   = LAST_BEAT;
    assign awsize  = 3'(SIZE);
    assign arsize  = 3'(SIZE);
    assign awburst = 2'b01;
    assign arburst = 2'b01;
    assign wstrb   = '1;

    assign unused_resp = ^{bresp[0], rresp[0]};
    assign start = req && !req_q && ((state == S_IDLE) || (state == S_DONE));

    // Next-state, counters and error bookkeeping
    always_comb begin
        state_d    = state;
        mode_d     = mode_q;
        abort_d    = abort_q;
        nburst_d   = nburst_q;
        base_d     = base_q;
        seed_d     = seed_q;
        beat_d     = beat;
        burst_d    = burst;
        g_d        = g;
        addr_d     = addr;
        err_d      = err;
        err_cnt_d  = err_cnt;
        err_addr_d = err_addr;
        ack_d      = (state == S_DONE) && !start;
        exp_data   = pattern(mode_q, seed_q, g);
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_d     = mode;
                    abort_d    = abort_en;
                    nburst_d   = nburst;
                    base_d     = base;
                    seed_d     = seed;
                    beat_d     = '0;
                    burst_d    = '0;
                    g_d        = '0;
                    addr_d     = base;
                    err_d      = '0;
                    err_cnt_d  = '0;
                    err_addr_d = '0;
                    state_d    = (nburst == '0) ? S_DONE : S_WADDR;
                end
            end
            S_WADDR: begin
                if (awready) state_d = S_WDATA;
            end
            S_WDATA: begin
                if (wready) begin
                    g_d = g + GW'(1);
                    if (beat == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_WRESP;
                    end else begin
                        beat_d = beat + 8'd1;
                    end
                end
            end
            S_WRESP: begin
                if (bvalid) begin
                    if (bresp[1]) err_d[2] = 1'b1;
                    burst_d = burst + CNT_WIDTH'(1);
                    if (abort_q && (err_d != 4'b0)) begin
                        state_d = S_DONE;
                    end else if (burst_d == nburst_q) begin
                        burst_d = '0;
                        g_d     = '0;
                        addr_d  = base_q;
                        state_d = S_RADDR;
                    end else begin
                        addr_d  = addr + ADDR_WIDTH'(BURST_BYTES);
                        state_d = S_WADDR;
                    end
                end
            end
            S_RADDR: begin
                if (arready) state_d = S_RDATA;
            end
            S_RDATA: begin
                if (rvalid) begin
                    if (rdata != exp_data) begin
                        if (!err[3]) err_addr_d = addr + (ADDR_WIDTH'(beat) << SIZE);
                        err_d[3] = 1'b1;
                        if (err_cnt != '1) err_cnt_d = err_cnt + CNT_WIDTH'(1);
                    end
                    if (rresp[1]) err_d[1] = 1'b1;
                    if (rlast != (beat == LAST_BEAT)) err_d[0] = 1'b1;
                    g_d = g + GW'(1);
                    if (beat == LAST_BEAT) begin
                        beat_d  = '0;
                        burst_d = burst + CNT_WIDTH'(1);
                        if ((abort_q && (err_d != 4'b0)) || (burst_d == nburst_q)) begin
                            state_d = S_DONE;
                        end else begin
                            addr_d  = addr + ADDR_WIDTH'(BURST_BYTES);
                            state_d = S_RADDR;
                        end
                    end else begin
                        beat_d = beat + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, configuration and registered outputs
    always_ff @(posedge clk) begin
        if (xrst) begin
            state    <= S_IDLE;
            req_q    <= 1'b0;
            mode_q   <= '0;
            abort_q  <= 1'b0;
            nburst_q <= '0;
            base_q   <= '0;
            seed_q   <= '0;
            beat     <= '0;
            burst    <= '0;
            g        <= '0;
            addr     <= '0;
            busy     <= 1'b0;
            ack      <= 1'b0;
            err      <= '0;
            err_cnt  <= '0;
            err_addr <= '0;
            awvalid  <= 1'b0;
            awaddr   <= '0;
            wvalid   <= 1'b0;
            wdata    <= '0;
            wlast    <= 1'b0;
            bready   <= 1'b0;
            arvalid  <= 1'b0;
            araddr   <= '0;
            rready   <= 1'b0;
        end else begin
            state    <= state_d;
            req_q    <= req;
            mode_q   <= mode_d;
            abort_q  <= abort_d;
            nburst_q <= nburst_d;
            base_q   <= base_d;
            seed_q   <= seed_d;
            beat     <= beat_d;
            burst    <= burst_d;
            g        <= g_d;
            addr     <= addr_d;
            busy     <= (state_d != S_IDLE) && (state_d != S_DONE);
            ack      <= ack_d;
            err      <= err_d;
            err_cnt  <= err_cnt_d;
            err_addr <= err_addr_d;
            awvalid  <= (state_d == S_WADDR);
            awaddr   <= addr_d;
            wvalid   <= (state_d == S_WDATA);
            wdata    <= (state_d == S_WDATA) ? pattern(mode_d, seed_d, g_d) : '0;
            wlast    <= (state_d == S_WDATA) && (beat_d == LAST_BEAT);
            bready   <= (state_d == S_WRESP);
            arvalid  <= (state_d == S_RADDR);
            araddr   <= addr_d;
            rready   <= (state_d == S_RDATA);
        end
    end

endmodule
